// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, access-type and FSM encodings, and the MEM/WB
// bundle type for the memory stage.
package mem_pkg;

  localparam int TYPE_BITS = 3;
  localparam int DATA_BITS = 32;
  localparam int ADDR_BITS = 32;
  localparam int REG_BITS  = 5;

  // Encodings not listed here (3, 6, 7) are handled as full-word accesses.
  typedef enum logic [TYPE_BITS-1:0] {
    DT_B  = 3'd0,
    DT_H  = 3'd1,
    DT_W  = 3'd2,
    DT_BU = 3'd4,
    DT_HU = 3'd5
  } dtype_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Registered MEM/WB bundle handed to the writeback stage.
  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic [REG_BITS-1:0]  rd;
    logic                 wr;
  } wb_t;

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the memory stage.
// Builds store byte enables and lane-replicated store data, and extracts the
// addressed byte/half from a read word with sign or zero extension.
// MEM_MISALIGN_TRAP_EN: when defined, flags half accesses with off[0] set and
// word accesses with any nonzero offset.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [TYPE_BITS-1:0] dtype_i,
  input  logic [1:0]           off_i,
  input  logic [DATA_BITS-1:0] st_data_i,
  input  logic [DATA_BITS-1:0] rdata_i,
  output logic [3:0]           be_o,
  output logic [DATA_BITS-1:0] wdata_o,
  output logic [DATA_BITS-1:0] load_o,
  output logic                 misalign_o
);

  logic [7:0]  rd_b;
  logic [15:0] rd_h;

  // Half accesses only look at off[1]; the low offset bit is ignored.
  assign rd_b = rdata_i[{off_i, 3'b000} +: 8];
  assign rd_h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Per access size: enables, replicated store data, extended load value.
  always_comb begin
    be_o       = 4'b1111;
    wdata_o    = st_data_i;
    load_o     = rdata_i;
    misalign_o = 1'b0;
    case (dtype_i)
      DT_B, DT_BU: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{st_data_i[7:0]}};
        load_o  = {{24{rd_b[7] & (dtype_i == DT_B)}}, rd_b};
      end
      DT_H, DT_HU: begin
        be_o    = 4'b0011 << {off_i[1], 1'b0};
        wdata_o = {2{st_data_i[15:0]}};
        load_o  = {{16{rd_h[15] & (dtype_i == DT_H)}}, rd_h};
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_o = off_i[0];
`endif
      end
      default: begin
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_o = |off_i;
`endif
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: consumer of the EX/MEM register. Issues data-memory requests,
// stalls upstream on wait states, aborts after TIMEOUT_CYC wait cycles and
// produces the registered MEM/WB writeback bundle.
// MEM_MISALIGN_TRAP_EN: when defined, misaligned half/word accesses issue no
// request, pulse mem_misalign and write back a bubble.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TYPE_BITS-1:0] ex_datatype,
  input  logic [DATA_BITS-1:0] ex_alu_out,
  input  logic [DATA_BITS-1:0] ex_dm_data,
  input  logic [ADDR_BITS-1:0] ex_pc2reg,
  input  logic [REG_BITS-1:0]  ex_rd_addr,
  input  logic                 ex_reg_wr,
  input  logic                 ex_rd_src,
  input  logic                 ex_dm2reg,
  input  logic                 ex_dm_rd,
  input  logic                 ex_dm_wr,
  output logic                 dm_req,
  output logic [3:0]           dm_we,
  output logic [ADDR_BITS-1:0] dm_addr,
  output logic [DATA_BITS-1:0] dm_wdata,
  input  logic                 dm_ready,
  input  logic [DATA_BITS-1:0] dm_rdata,
  output logic                 mem_stall,
  output logic                 mem_err,
  output logic                 mem_misalign,
  output logic [DATA_BITS-1:0] wb_data,
  output logic [REG_BITS-1:0]  wb_rd_addr,
  output logic                 wb_reg_wr
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_MAX = cnt_t'(TIMEOUT_CYC);

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  wb_t    wb_q, wb_d;
  logic   err_q;

  logic                 acc;
  logic                 misalign;
  logic                 req_vld;
  logic                 abort;
  logic [3:0]           be;
  logic [DATA_BITS-1:0] load_ext;

  mem_lane_align u_align (
    .dtype_i    (ex_datatype),
    .off_i      (ex_alu_out[1:0]),
    .st_data_i  (ex_dm_data),
    .rdata_i    (dm_rdata),
    .be_o       (be),
    .wdata_o    (dm_wdata),
    .load_o     (load_ext),
    .misalign_o (misalign)
  );

  assign acc     = ex_dm_rd | ex_dm_wr;
  assign req_vld = acc & ~misalign;

  // Request FSM: zero-wait completes in IDLE; otherwise count wait cycles in
  // WAIT and abort once the count reaches TIMEOUT_CYC without dm_ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_vld && !dm_ready) begin
          state_d = WAIT;
          cnt_d   = cnt_t'(1);
        end
      end
      WAIT: begin
        if (dm_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          abort   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Inputs are frozen by the stall while in WAIT, so address/enables/data
  // stay stable without extra holding registers.
  assign dm_req    = ~rst & ~abort & (req_vld | (state_q == WAIT));
  assign dm_we     = (dm_req && ex_dm_wr) ? be : 4'b0000;
  assign dm_addr   = {ex_alu_out[ADDR_BITS-1:2], 2'b00};
  assign mem_stall = dm_req & ~dm_ready & ~abort;

  // MEM/WB next value: bubble on stall, abort or trapped access; x0 never written.
  always_comb begin
    wb_d    = wb_q;
    wb_d.wr = 1'b0;
    if (!(mem_stall || abort || (acc && misalign))) begin
      wb_d.wr   = ex_reg_wr & (ex_rd_addr != '0);
      wb_d.rd   = ex_rd_addr;
      wb_d.data = ex_dm2reg ? load_ext : (ex_rd_src ? ex_pc2reg : ex_alu_out);
    end
  end

  // MEM/WB register and the timeout error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wb_q  <= wb_d;
      err_q <= abort;
    end
  end

  assign wb_data    = wb_q.data;
  assign wb_rd_addr = wb_q.rd;
  assign wb_reg_wr  = wb_q.wr;
  assign mem_err    = err_q;

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q;

  // One-cycle pulse for an access rejected as misaligned.
  always_ff @(posedge clk) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= acc & misalign;
  end

  assign mem_misalign = mis_q;
`else
  assign mem_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios plus randomized loads/stores/ALU ops
// checked against a byte-array memory model and size/offset arithmetic.
module tb_mem_stage;
  import mem_pkg::*;

  localparam int TO   = 4;
  localparam int MEMB = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ex_datatype;
  logic [31:0] ex_alu_out, ex_dm_data, ex_pc2reg;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_wr, ex_rd_src, ex_dm2reg, ex_dm_rd, ex_dm_wr;
  logic        dm_req;
  logic [3:0]  dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        mem_stall, mem_err, mem_misalign;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd_addr;
  logic        wb_reg_wr;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_datatype(ex_datatype), .ex_alu_out(ex_alu_out), .ex_dm_data(ex_dm_data),
    .ex_pc2reg(ex_pc2reg), .ex_rd_addr(ex_rd_addr), .ex_reg_wr(ex_reg_wr),
    .ex_rd_src(ex_rd_src), .ex_dm2reg(ex_dm2reg), .ex_dm_rd(ex_dm_rd), .ex_dm_wr(ex_dm_wr),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_stall(mem_stall), .mem_err(mem_err), .mem_misalign(mem_misalign),
    .wb_data(wb_data), .wb_rd_addr(wb_rd_addr), .wb_reg_wr(wb_reg_wr)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0]  mem [MEMB];
  logic [31:0] exp_wbd;
  logic [4:0]  exp_wbrd;

  always @(posedge clk) if (!rst) assert (!(ex_dm_rd && ex_dm_wr));

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mword(input logic [31:0] a);
    int b;
    b = int'(a % MEMB) & ~3;
    return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
  endfunction

  task automatic idle_inputs();
    ex_dm_rd = 0; ex_dm_wr = 0; ex_reg_wr = 0; ex_rd_src = 0; ex_dm2reg = 0;
    ex_datatype = 3'd2; ex_rd_addr = 0;
    ex_alu_out = 0; ex_dm_data = 0; ex_pc2reg = 0;
    dm_ready = 0; dm_rdata = 0;
  endtask

  // One instruction through the stage. wait_n > TO means the memory never answers.
  task automatic do_op(input bit rd, input bit wr, input logic [2:0] dt,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] pc, input logic [4:0] rdn,
                       input bit reg_wr, input bit rd_src, input bit dm2reg,
                       input int wait_n);
    int n;
    bit sgn, acc, mis, last, abrt;
    logic [31:0] base, exp_we, exp_wd, ld, exp_wb, word;
    n    = (dt == 3'd0 || dt == 3'd4) ? 1 : (dt == 3'd1 || dt == 3'd5) ? 2 : 4;
    sgn  = (dt == 3'd0 || dt == 3'd1);
    base = addr - (addr % n);
    acc  = rd | wr;
    mis  = 0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = acc && (addr % n != 0);
`endif
    exp_we = wr ? (((1 << n) - 1) << (base % 4)) : 0;
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = data[8*(i % n) +: 8];
    ld = 0;
    for (int i = 0; i < n; i++) ld = ld | (32'(mem[(base + i) % MEMB]) << (8 * i));
    if (sgn && n < 4 && ld[8*n-1]) ld = ld | (32'hFFFF_FFFF << (8 * n));
    exp_wb = dm2reg ? ld : (rd_src ? pc : addr);
    word = mword(addr);

    ex_dm_rd = rd; ex_dm_wr = wr; ex_datatype = dt; ex_alu_out = addr;
    ex_dm_data = data; ex_pc2reg = pc; ex_rd_addr = rdn;
    ex_reg_wr = reg_wr; ex_rd_src = rd_src; ex_dm2reg = dm2reg;

    abrt = 0;
    if (acc && !mis) begin
      for (int k = 0; k <= TO; k++) begin
        last = (k == wait_n);
        abrt = (k == TO) && !last;
        dm_ready = last;
        dm_rdata = last ? word : $urandom;
        @(negedge clk);
        chk("dm_req", 32'(dm_req), 32'(!abrt));
        chk("mem_stall", 32'(mem_stall), 32'(!last && !abrt));
        if (!abrt) begin
          chk("dm_addr", dm_addr, addr & ~32'd3);
          chk("dm_we", 32'(dm_we), exp_we);
          if (wr) chk("dm_wdata", dm_wdata, exp_wd);
        end
        @(posedge clk); #1;
        if (last || abrt) break;
        chk("stall_bubble", 32'(wb_reg_wr), 0);
        chk("stall_hold", wb_data, exp_wbd);
      end
    end else begin
      dm_ready = 1'($urandom_range(0, 1));
      dm_rdata = $urandom;
      @(negedge clk);
      chk("dm_req_none", 32'(dm_req), 0);
      chk("stall_none", 32'(mem_stall), 0);
      @(posedge clk); #1;
    end
    dm_ready = 0;

    chk("mem_err", 32'(mem_err), 32'(abrt));
    chk("mem_misalign", 32'(mem_misalign), 32'(mis));
    if (abrt || mis) begin
      chk("bubble_wr", 32'(wb_reg_wr), 0);
      chk("bubble_hold", wb_data, exp_wbd);
    end else begin
      exp_wbd  = exp_wb;
      exp_wbrd = rdn;
      chk("wb_reg_wr", 32'(wb_reg_wr), 32'(reg_wr && rdn != 0));
      chk("wb_data", wb_data, exp_wbd);
      chk("wb_rd_addr", 32'(wb_rd_addr), 32'(exp_wbrd));
      if (wr) for (int i = 0; i < n; i++) mem[(base + i) % MEMB] = data[8*i +: 8];
    end
  endtask

  initial begin
    int kind, w;
    logic [2:0] dt;
    for (int i = 0; i < MEMB; i++) mem[i] = 8'($urandom);
    idle_inputs();
    rst = 1;
    // Access presented during reset must not reach the memory port.
    ex_dm_rd = 1; ex_alu_out = 32'h20; ex_reg_wr = 1; ex_rd_addr = 5'd7; ex_dm2reg = 1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_dm_req", 32'(dm_req), 0);
      chk("rst_stall", 32'(mem_stall), 0);
      @(posedge clk); #1;
    end
    chk("rst_wb_wr", 32'(wb_reg_wr), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", 32'(wb_rd_addr), 0);
    chk("rst_err", 32'(mem_err), 0);
    chk("rst_mis", 32'(mem_misalign), 0);
    exp_wbd = 0; exp_wbrd = 0;
    idle_inputs();
    rst = 0;

    // 1: SW zero-wait
    do_op(0, 1, DT_W, 32'h104, 32'h1122_3344, 0, 0, 0, 0, 0, 0);
    // 2: LB 0x103 with two wait states
    mem[32'h100] = 8'hFF; mem[32'h101] = 8'hFF; mem[32'h102] = 8'hFF; mem[32'h103] = 8'h80;
    do_op(1, 0, DT_B, 32'h103, 0, 0, 5'd5, 1, 0, 1, 2);
    chk("t2_lb", wb_data, 32'hFFFF_FF80);
    // 3: SB lane 2, then LHU from the upper half
    do_op(0, 1, DT_B, 32'h2, 32'h0000_00AB, 0, 0, 0, 0, 0, 0);
    mem[2] = 8'h01; mem[3] = 8'h80;
    do_op(1, 0, DT_HU, 32'h2, 0, 0, 5'd6, 1, 0, 1, 1);
    chk("t3_lhu", wb_data, 32'h0000_8001);
    // 4: timeout, then a zero-wait access proves the FSM is back in IDLE
    do_op(1, 0, DT_W, 32'h40, 0, 0, 5'd9, 1, 0, 1, 99);
    do_op(1, 0, DT_W, 32'h44, 0, 0, 5'd9, 1, 0, 1, 0);
    // ready exactly on the last allowed wait cycle completes, not aborts
    do_op(1, 0, DT_W, 32'h48, 0, 0, 5'd10, 1, 0, 1, TO);
    // 5: JAL link writes, rd = x1 and rd = x0
    do_op(0, 0, DT_W, 32'h1234, 0, 32'h40, 5'd1, 1, 1, 0, 0);
    chk("t5_jal", wb_data, 32'h40);
    do_op(0, 0, DT_W, 32'h1234, 0, 32'h44, 5'd0, 1, 1, 0, 0);

    // 6: reset while in WAIT drops the request with no writeback
    ex_dm_rd = 1; ex_datatype = DT_W; ex_alu_out = 32'h10; ex_rd_addr = 5'd3;
    ex_reg_wr = 1; ex_dm2reg = 1; dm_ready = 0;
    @(negedge clk);
    chk("t6_req", 32'(dm_req), 1);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("t6_rst_req", 32'(dm_req), 0);
    chk("t6_rst_stall", 32'(mem_stall), 0);
    @(posedge clk); #1;
    rst = 0;
    idle_inputs();
    exp_wbd = 0; exp_wbrd = 0;
    chk("t6_wb_wr", 32'(wb_reg_wr), 0);
    chk("t6_wb_data", wb_data, 0);
    @(negedge clk);
    chk("t6_req_after", 32'(dm_req), 0);
    @(posedge clk); #1;
    // LW at 0x6: trapped when the misalign trap is built in, else word at 0x4
    do_op(1, 0, DT_W, 32'h6, 0, 0, 5'd4, 1, 0, 1, 0);

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      kind = $urandom_range(0, 2);
      dt   = 3'($urandom_range(0, 7));
      w    = $urandom_range(0, TO + 1);
      case (kind)
        0: do_op(1, 0, dt, $urandom_range(0, MEMB - 1), 0, $urandom, 5'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, w);
        1: do_op(0, 1, dt, $urandom_range(0, MEMB - 1), $urandom, $urandom, 5'($urandom),
                 0, 0, 0, w);
        default: do_op(0, 0, dt, $urandom, $urandom, $urandom, 5'($urandom),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
